// File: rtl/mem_rd_pkg.sv
// rtl/mem_rd_pkg.sv - shared state encoding and size-mask helper for the read aligner
//
// Purpose: FSM state type for mem_rd_align_unit and a byte-enable helper that
//          turns an effective access size into a low-justified byte mask.
// Ports:   none (package)
package mem_rd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ACC1    = 3'd1,
    ST_ACC2    = 3'd2,
    ST_IO_WAIT = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  // Widest output the mask helper supports; callers truncate to their own width.
  localparam int MAX_MASK_BYTES = 64;

  // Bit i set when byte i lies inside an access of size_eff bytes.
  function automatic logic [MAX_MASK_BYTES-1:0] size_mask(input int size_eff);
    logic [MAX_MASK_BYTES-1:0] m;
    for (int i = 0; i < MAX_MASK_BYTES; i++) begin
      m[i] = (i < size_eff);
    end
    return m;
  endfunction

endpackage

// File: rtl/byte_rotate_right.sv
// rtl/byte_rotate_right.sv - byte-granular right rotation of a line
//
// Purpose: out byte i = in byte (shift + i) mod NUM_BYTES. Only the low
//          OUT_BYTES bytes of the rotated line are produced.
// Ports:   data_in  [NUM_BYTES*8]  line to rotate
//          shift    [SHIFT_W]      rotation amount in bytes
//          data_out [OUT_BYTES*8]  low bytes of the rotated line
module byte_rotate_right #(
  parameter int NUM_BYTES = 16,
  parameter int OUT_BYTES = NUM_BYTES,
  localparam int SHIFT_W = $clog2(NUM_BYTES)
) (
  input  logic [NUM_BYTES*8-1:0] data_in,
  input  logic [SHIFT_W-1:0]     shift,
  output logic [OUT_BYTES*8-1:0] data_out
);

  always_comb begin
    data_out = '0;
    for (int i = 0; i < OUT_BYTES; i++) begin
      // NUM_BYTES is a power of two, so the modulo is a plain wrap of the index.
      data_out[i*8 +: 8] = data_in[((int'(shift) + i) % NUM_BYTES)*8 +: 8];
    end
  end

endmodule

// File: rtl/mem_rd_align_unit.sv
// rtl/mem_rd_align_unit.sv - load data aligner between dcache/IO read ports and operand path
//
// Purpose: accepts one load request, rotates the returned dcache line by the
//          request offset, merges a second line when the access crosses a line
//          boundary, zero-extends beyond the access size (or takes IO data) and
//          holds the result under a valid/ready handshake.
// Ports:   clk, rst                  clock, synchronous active-high reset
//          req_valid/req_ready       request handshake; ready only in IDLE
//          req_offset/size/is_io     request fields, latched on acceptance
//          dc_rd_data, dc_hit        dcache line and its strobe
//          io_rd_data, io_ack        IO read data and its strobe
//          split                     current request spans two lines
//          out_valid/ready/data      aligned result handshake
module mem_rd_align_unit
  import mem_rd_pkg::*;
#(
  parameter int LINE_BYTES = 16,
  parameter int DATA_BYTES = 8,
  parameter int IO_W       = 32,
  localparam int OFF_W     = $clog2(LINE_BYTES),
  localparam int SZ_W      = $clog2(DATA_BYTES) + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [OFF_W-1:0]        req_offset,
  input  logic [SZ_W-1:0]         req_size,
  input  logic                    req_is_io,
  input  logic [LINE_BYTES*8-1:0] dc_rd_data,
  input  logic                    dc_hit,
  input  logic [IO_W-1:0]         io_rd_data,
  input  logic                    io_ack,
  output logic                    split,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_BYTES*8-1:0] out_data
);

  localparam int DATA_W = DATA_BYTES * 8;

  state_t             state;
  logic [OFF_W-1:0]   off_q;
  logic [SZ_W-1:0]    size_q;
  logic               split_q;
  logic [DATA_W-1:0]  hold_q;
  logic [DATA_W-1:0]  out_data_q;

  logic [SZ_W-1:0]    req_size_eff;
  logic               req_split;
  logic [DATA_BYTES-1:0] byte_en;
  logic [DATA_W-1:0]  keep_mask;
  logic [DATA_W-1:0]  rot_data;
  logic [DATA_W-1:0]  merged;
  logic [DATA_W-1:0]  io_ext;

  // Rotation always uses the latched offset: both line reads of a split access
  // rotate by the same amount, so the merge is a per-byte select.
  byte_rotate_right #(
    .NUM_BYTES (LINE_BYTES),
    .OUT_BYTES (DATA_BYTES)
  ) u_rot (
    .data_in  (dc_rd_data),
    .shift    (off_q),
    .data_out (rot_data)
  );

  always_comb begin
    req_size_eff = (req_size == '0) ? SZ_W'(DATA_BYTES) : req_size;
    req_split    = (int'(req_offset) + int'(req_size_eff)) > LINE_BYTES;

    byte_en   = DATA_BYTES'(size_mask(int'(size_q)));
    keep_mask = '0;
    merged    = '0;
    for (int i = 0; i < DATA_BYTES; i++) begin
      keep_mask[i*8 +: 8] = {8{byte_en[i]}};
      // Bytes before the line boundary came from the first line read.
      merged[i*8 +: 8] = (i < LINE_BYTES - int'(off_q)) ? hold_q[i*8 +: 8]
                                                         : rot_data[i*8 +: 8];
    end

    io_ext = DATA_W'(io_rd_data);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      off_q      <= '0;
      size_q     <= '0;
      split_q    <= 1'b0;
      hold_q     <= '0;
      out_data_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            off_q   <= req_offset;
            size_q  <= req_size_eff;
            // IO accesses never touch the line path, so they never split.
            split_q <= req_split && !req_is_io;
            state   <= req_is_io ? ST_IO_WAIT : ST_ACC1;
          end
        end
        ST_ACC1: begin
          if (dc_hit) begin
            if (split_q) begin
              hold_q <= rot_data;
              state  <= ST_ACC2;
            end else begin
              out_data_q <= rot_data & keep_mask;
              state      <= ST_DONE;
            end
          end
        end
        ST_ACC2: begin
          if (dc_hit) begin
            out_data_q <= merged & keep_mask;
            state      <= ST_DONE;
          end
        end
        ST_IO_WAIT: begin
          if (io_ack) begin
            out_data_q <= io_ext & keep_mask;
            state      <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            split_q <= 1'b0;
            state   <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign split     = split_q;
  assign out_data  = out_data_q;

endmodule
